prog_bus_reader: RTL and testbench

- Reader end of the shared 24-bit program-memory bus. The program-memory output latch drives the bus only while its enable is high and floats it otherwise; this block generates that enable.
- Issues sequential word reads starting at a loaded PC, holds the enable through the access, samples the bus, and queues captured words for the decoder.
- Words reach the decoder through a valid/ready interface.
- Sits between the program-memory latch and instruction decode as the prefetch path.

---
 rtl/prog_bus_pkg.sv | 20 ++
 rtl/prefetch_fifo.sv | 50 +++++
 rtl/prog_bus_reader.sv | 100 ++++++++++
 tb/tb_prog_bus_reader.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_bus_pkg.sv
// Shared types for the program-memory bus reader.
// Entry layout and FSM states used by the reader and its queue.
package prog_bus_pkg;
  localparam int ADDR_W = 23;
  localparam int PC_STEP = 2;

  typedef logic [ADDR_W-1:0] pc_t;
  typedef logic [23:0] instr_t;

  typedef struct packed {
    instr_t word;
    pc_t    pc;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    STALL
  } rd_state_e;
endpackage

// File: rtl/prefetch_fifo.sv
// Synchronous prefetch queue of fetched words.
// Head is read straight from storage; clear empties it in one edge.
module prefetch_fifo
  import prog_bus_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  fetch_entry_t             din,
  output fetch_entry_t             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  fetch_entry_t mem [DEPTH];
  logic [AW-1:0] wr;
  logic [AW-1:0] rd;
  logic [AW:0]   cnt;

  assign full  = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign count = cnt;
  assign dout  = mem[rd];

  always_ff @(posedge clk_i) begin
    if (push) mem[wr] <= din;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear) begin
      wr  <= '0;
      rd  <= '0;
      cnt <= '0;
    end else begin
      if (push) wr <= wr + AW'(1);
      if (pop) rd <= rd + AW'(1);
      unique case ({push, pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

// File: rtl/prog_bus_reader.sv
// Prefetch reader on the shared program-memory bus.
// Drives the latch enable, samples words and queues them for decode.
module prog_bus_reader
  import prog_bus_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int RD_LATENCY = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] start_addr_i,
  input  logic              flush_i,
  output logic              bus_en_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  input  logic [23:0]       bus_data_i,
  output logic              instr_valid_o,
  output logic [23:0]       instr_o,
  output logic [ADDR_W-1:0] instr_pc_o,
  input  logic              instr_ready_i,
  output logic              busy_o
);
  localparam int CW = $clog2(RD_LATENCY + 1);
  localparam int NW = $clog2(DEPTH) + 1;

  rd_state_e     state;
  pc_t           pc;
  logic [CW-1:0] cnt;
  logic          last;
  logic          clear;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  logic          room2;
  logic [NW-1:0] count;
  fetch_entry_t  entry;
  fetch_entry_t  head;

  assign last  = cnt == CW'(RD_LATENCY - 1);
  assign clear = start_i || flush_i;
  assign push  = (state == READ) && last && !clear;
  assign pop   = !empty && instr_ready_i && !clear;
  // Keep streaming only if a slot is still free after this push.
  assign room2 = count <= NW'(DEPTH - 2);
  assign entry = '{word: bus_data_i, pc: pc};

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state <= IDLE;
      pc    <= '0;
      cnt   <= '0;
    end else if (start_i) begin
      state <= READ;
      pc    <= {start_addr_i[ADDR_W-1:1], 1'b0};
      cnt   <= '0;
    end else if (flush_i) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      unique case (1'b1)
        state == READ: begin
          if (last) begin
            pc    <= pc + pc_t'(PC_STEP);
            cnt   <= '0;
            state <= room2 ? READ : STALL;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        state == STALL: begin
          if (!full) state <= READ;
        end
        default: state <= state;
      endcase
    end
  end

  prefetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .push  (push),
    .pop   (pop),
    .clear (clear),
    .din   (entry),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign bus_en_o      = state == READ;
  assign busy_o        = state != IDLE;
  assign bus_addr_o    = pc;
  assign instr_valid_o = !empty;
  assign instr_o       = empty ? '0 : head.word;
  assign instr_pc_o    = empty ? '0 : head.pc;
endmodule

// File: tb/tb_prog_bus_reader.sv
// Scoreboard bench for prog_bus_reader: directed cases then random.
// Expected stream is the sequential word run from each start address.
module tb_prog_bus_reader;
  localparam logic [23:0] KEY = 24'hA00000;

  typedef struct {
    logic [23:0] w;
    logic [22:0] pc;
  } exp_t;

  logic        clk;
  logic        rst_ni;
  logic        start;
  logic [22:0] start_addr;
  logic        flush;
  logic        bus_en;
  logic [22:0] bus_addr;
  logic [23:0] bus_data;
  logic        valid;
  logic [23:0] instr;
  logic [22:0] instr_pc;
  logic        ready;
  logic        busy;
  logic [23:0] junk;

  int checks = 0;
  int failures = 0;
  exp_t sb[$];

  prog_bus_reader #(
    .DEPTH(4),
    .RD_LATENCY(2)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .start_i      (start),
    .start_addr_i (start_addr),
    .flush_i      (flush),
    .bus_en_o     (bus_en),
    .bus_addr_o   (bus_addr),
    .bus_data_i   (bus_data),
    .instr_valid_o(valid),
    .instr_o      (instr),
    .instr_pc_o   (instr_pc),
    .instr_ready_i(ready),
    .busy_o       (busy)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  always @(posedge clk) junk = 24'($urandom);
  assign bus_data = bus_en ? (KEY ^ {1'b0, bus_addr}) : junk;

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", n, a, e);
    end
  endtask

  task automatic sb_load(input logic [22:0] a);
    logic [22:0] p;
    sb.delete();
    p = {a[22:1], 1'b0};
    for (int k = 0; k < 512; k++) begin
      sb.push_back('{KEY ^ {1'b0, p}, p});
      p = p + 23'd2;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [22:0] a);
    start = 1;
    start_addr = a;
    sb_load(a);
    tick();
    start = 0;
  endtask

  task automatic check_zero(input string t);
    chk({t, "_bus_en"}, 32'(bus_en), 0);
    chk({t, "_bus_addr"}, 32'(bus_addr), 0);
    chk({t, "_valid"}, 32'(valid), 0);
    chk({t, "_instr"}, 32'(instr), 0);
    chk({t, "_instr_pc"}, 32'(instr_pc), 0);
    chk({t, "_busy"}, 32'(busy), 0);
  endtask

  // Monitor: consumes expectations on each accepted word.
  logic        hold_chk = 0;
  logic [23:0] held_w;
  logic [22:0] held_pc;
  always @(negedge clk) begin
    exp_t e;
    if (rst_ni && !start && !flush) begin
      if (hold_chk) begin
        checks++;
        if (instr !== held_w || instr_pc !== held_pc) begin
          failures++;
          $display("FAIL hold got=%0h/%0h exp=%0h/%0h",
                   instr, instr_pc, held_w, held_pc);
        end
      end
      if (valid && ready) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL sb_extra got=%0h/%0h exp=none",
                   instr, instr_pc);
        end else begin
          e = sb.pop_front();
          if (instr !== e.w || instr_pc !== e.pc) begin
            failures++;
            $display("FAIL sb_word got=%0h/%0h exp=%0h/%0h",
                     instr, instr_pc, e.w, e.pc);
          end
        end
      end
    end
    hold_chk = rst_ni && !start && !flush && valid && !ready;
    held_w = instr;
    held_pc = instr_pc;
  end

  initial begin
    int n;
    int r;
    int since;
    rst_ni = 0;
    start = 0;
    start_addr = '0;
    flush = 0;
    ready = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    tick();
    rst_ni = 1;

    // 1: streaming, one word every 2 cycles
    ready = 1;
    do_start(23'h000200);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk($sformatf("t1_bus_en_%0d", k), 32'(bus_en), 1);
      chk($sformatf("t1_valid_%0d", k), 32'(valid),
          32'(k >= 2 && k % 2 == 0));
      tick();
    end

    // 2: backpressure fills queue, then one more read per pop
    ready = 0;
    do_start(23'h000200);
    repeat (12) tick();
    @(negedge clk);
    chk("t2_bus_en", 32'(bus_en), 0);
    chk("t2_busy", 32'(busy), 1);
    chk("t2_head", 32'(instr), 32'h00A00200);
    chk("t2_head_pc", 32'(instr_pc), 32'h200);
    tick();
    ready = 1;
    tick();
    ready = 0;
    n = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus_en) n++;
      tick();
    end
    chk("t2_extra_reads", 32'(n), 2);
    @(negedge clk);
    chk("t2_head2", 32'(instr), 32'h00A00202);
    tick();
    ready = 1;
    repeat (6) tick();

    // 3: flush on first READ cycle with 2 entries queued
    ready = 0;
    do_start(23'h000300);
    repeat (4) tick();
    flush = 1;
    sb.delete();
    tick();
    flush = 0;
    @(negedge clk);
    chk("t3_valid", 32'(valid), 0);
    chk("t3_bus_en", 32'(bus_en), 0);
    chk("t3_busy", 32'(busy), 0);
    repeat (4) tick();
    @(negedge clk);
    chk("t3_no_push", 32'(valid), 0);
    tick();

    // 4: restart while busy, odd address
    ready = 1;
    do_start(23'h000200);
    repeat (5) tick();
    do_start(23'h000401);
    @(negedge clk);
    chk("t4_addr", 32'(bus_addr), 32'h400);
    chk("t4_cleared", 32'(valid), 0);
    tick();
    tick();
    @(negedge clk);
    chk("t4_first_valid", 32'(valid), 1);
    chk("t4_first_pc", 32'(instr_pc), 32'h400);
    repeat (6) tick();

    // 5: address wrap
    do_start(23'h7FFFFE);
    tick();
    tick();
    @(negedge clk);
    chk("t5_wrap_addr", 32'(bus_addr), 0);
    chk("t5_wrap_en", 32'(bus_en), 1);
    repeat (6) tick();

    // 6: reset mid-READ with 3 entries queued
    ready = 0;
    do_start(23'h000100);
    repeat (6) tick();
    rst_ni = 0;
    sb.delete();
    tick();
    rst_ni = 1;
    @(negedge clk);
    check_zero("t6");
    repeat (5) tick();
    @(negedge clk);
    chk("t6_idle_busy", 32'(busy), 0);
    chk("t6_idle_en", 32'(bus_en), 0);
    chk("t6_idle_valid", 32'(valid), 0);
    tick();

    // Random traffic
    since = 0;
    ready = 1;
    do_start(23'($urandom));
    for (int c = 0; c < 3000; c++) begin
      r = $urandom_range(0, 999);
      ready = $urandom_range(0, 3) != 0;
      if (r < 4) begin
        rst_ni = 0;
        sb.delete();
      end else if (r < 25 || since > 300) begin
        start = 1;
        start_addr = 23'($urandom);
        sb_load(start_addr);
        since = 0;
      end else if (r < 40) begin
        flush = 1;
        sb.delete();
      end
      tick();
      rst_ni = 1;
      start = 0;
      flush = 0;
      since++;
    end
    ready = 1;
    repeat (10) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
